// File: rtl/gj_axis_uart_pkg.sv
// rtl/gj_axis_uart_pkg.sv - shared mode-bit indices, FSM states and parity helper for the gjAxisUart pair
package gj_axis_uart_pkg;

  localparam int STOP1B     = 0;
  localparam int PAR_EVEN   = 1;
  localparam int PAR_ODD    = 2;
  localparam int NOP_EN     = 3;
  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BREAK,
    DONE
  } uart_state_e;

  function automatic logic parity_on(input logic [3:0] mode);
    return mode[PAR_EVEN] | mode[PAR_ODD];
  endfunction

  // Even parity takes precedence when both parity bits are set.
  function automatic logic parity_bit(input logic [FRAME_BITS-1:0] data, input logic [3:0] mode);
    return mode[PAR_EVEN] ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/gj_axis_uart_rx_if.sv
// rtl/gj_axis_uart_rx_if.sv - AXI-Stream byte channel from the UART receiver
interface gj_axis_uart_rx_if;
  import gj_axis_uart_pkg::*;

  logic                  rx_tvalid;
  logic                  rx_tready;
  logic [FRAME_BITS-1:0] rx_tdata;
  logic                  rx_tlast;

  modport master (output rx_tvalid, rx_tdata, rx_tlast, input rx_tready);
  modport slave  (input rx_tvalid, rx_tdata, rx_tlast, output rx_tready);

endinterface

// File: rtl/gj_uart_rx_sampler.sv
// rtl/gj_uart_rx_sampler.sv - rx synchronizer, sub-bit tick counter and bit-centre strobe
// Optional GJAXISUARTRX_MAJVOTE_EN: 2-of-3 vote over the three ticks around the bit centre.
module gj_uart_rx_sampler #(
  parameter int OVS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic rx,
  input  logic active,
  output logic rxs,
  output logic bit_strobe,
  output logic bit_val
);
  localparam int TC_W = $clog2(OVS);

  logic            rx_meta;
  logic [TC_W-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // tcnt is held at 0 outside a frame so the start edge defines the bit phase.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      tcnt <= '0;
    end else if (clk_en) begin
      tcnt <= (tcnt == TC_W'(OVS - 1)) ? '0 : tcnt + TC_W'(1);
    end
  end

`ifdef GJAXISUARTRX_MAJVOTE_EN
  logic s_a, s_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else if (clk_en && active) begin
      if (tcnt == TC_W'(OVS / 2 - 2)) s_a <= rxs;
      if (tcnt == TC_W'(OVS / 2 - 1)) s_b <= rxs;
    end
  end

  // The decision lands on the third sample, one tick past the centre.
  assign bit_strobe = clk_en && active && (tcnt == TC_W'(OVS / 2));
  assign bit_val    = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
`else
  assign bit_strobe = clk_en && active && (tcnt == TC_W'(OVS / 2 - 1));
  assign bit_val    = rxs;
`endif

endmodule

// File: rtl/gj_axis_uart_rx.sv
// rtl/gj_axis_uart_rx.sv - oversampling UART receiver with AXI-Stream byte output and idle-gap tlast
// Optional GJAXISUARTRX_MAJVOTE_EN selects majority-vote bit sampling in gj_uart_rx_sampler.
module gj_axis_uart_rx
  import gj_axis_uart_pkg::*;
#(
  parameter int OVS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [3:0]        mode,
  input  logic [15:0]       rx_idle,
  input  logic              rx,
  gj_axis_uart_rx_if.master axis,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              rxEn
);
  localparam int TC_W = $clog2(OVS);

  uart_state_e           state;
  logic                  rxs, bit_strobe, bit_val, active;
  logic [2:0]            bcnt;
  logic [FRAME_BITS-1:0] shreg, pend_data, tdata_q, rel_data;
  logic                  par_flag, pend_valid, tvalid_q, tlast_q;
  logic [TC_W-1:0]       idle_tcnt;
  logic [15:0]           idle_bits;
  logic                  idle_wrap, rel_en, rel_last;

  assign active    = state inside {START, DATA, PARITY, STOP1, STOP2};
  assign idle_wrap = clk_en && (idle_tcnt == TC_W'(OVS - 1));

  assign axis.rx_tvalid = tvalid_q;
  assign axis.rx_tdata  = tdata_q;
  assign axis.rx_tlast  = tlast_q;

  gj_uart_rx_sampler #(.OVS(OVS)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .rx         (rx),
    .active     (active),
    .rxs        (rxs),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val)
  );

  // Release of a byte towards the output register: direct at DONE, idle timeout, or next valid start.
  always_comb begin
    rel_en   = 1'b0;
    rel_last = 1'b0;
    rel_data = pend_data;
    case (state)
      DONE: begin
        rel_data = shreg;
        if (!mode[NOP_EN]) begin
          rel_en = 1'b1;
        end else if (rx_idle == 16'd0) begin
          rel_en   = 1'b1;
          rel_last = 1'b1;
        end
      end
      IDLE: begin
        if (mode[NOP_EN] && pend_valid && idle_wrap &&
            ({1'b0, idle_bits} + 17'd1 == {1'b0, rx_idle})) begin
          rel_en   = 1'b1;
          rel_last = 1'b1;
        end
      end
      START: begin
        if (pend_valid && bit_strobe && !bit_val) rel_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rxEn       <= 1'b0;
      bcnt       <= '0;
      shreg      <= '0;
      par_flag   <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      idle_tcnt  <= '0;
      idle_bits  <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;

      if (tvalid_q && axis.rx_tready) tvalid_q <= 1'b0;
      if (rel_en) begin
        if (!tvalid_q || axis.rx_tready) begin
          tvalid_q <= 1'b1;
          tdata_q  <= rel_data;
          tlast_q  <= rel_last;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (clk_en && mode[NOP_EN] && pend_valid) begin
            idle_tcnt <= idle_wrap ? '0 : idle_tcnt + TC_W'(1);
            if (idle_wrap) idle_bits <= idle_bits + 16'd1;
          end
          if (rel_en) pend_valid <= 1'b0;
          if (clk_en && !rxs) begin
            state <= START;
            rxEn  <= 1'b1;
          end
        end
        START: begin
          if (bit_strobe) begin
            if (bit_val) begin
              state <= IDLE;
              rxEn  <= 1'b0;
            end else begin
              state    <= DATA;
              bcnt     <= '0;
              par_flag <= 1'b0;
              if (rel_en) pend_valid <= 1'b0;
            end
          end
        end
        DATA: begin
          if (bit_strobe) begin
            shreg <= {bit_val, shreg[FRAME_BITS-1:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == 3'(FRAME_BITS - 1)) state <= parity_on(mode) ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (bit_strobe) begin
            par_flag <= (bit_val != parity_bit(shreg, mode));
            state    <= STOP1;
          end
        end
        STOP1: begin
          if (bit_strobe) begin
            if (!bit_val) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              state <= mode[STOP1B] ? DONE : STOP2;
            end
          end
        end
        STOP2: begin
          if (bit_strobe) begin
            if (!bit_val) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              state <= DONE;
            end
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
            rxEn  <= 1'b0;
          end
        end
        DONE: begin
          parity_err <= par_flag;
          if (!rel_en) begin
            pend_valid <= 1'b1;
            pend_data  <= shreg;
          end
          idle_tcnt <= '0;
          idle_bits <= '0;
          state     <= IDLE;
          rxEn      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gj_axis_uart_rx.sv
// tb/tb_gj_axis_uart_rx.sv - directed and randomized frames against a frame-level reference model
module tb_gj_axis_uart_rx;
  localparam int OVS      = 16;
  localparam int CE_DIV   = 4;
  localparam int BIT_CLKS = OVS * CE_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        rx = 1'b1;
  logic [3:0]  mode = 4'b0001;
  logic [15:0] rx_idle = 16'd0;
  logic        parity_err, frame_err, overrun, rxEn;

  gj_axis_uart_rx_if axis ();

  gj_axis_uart_rx #(.OVS(OVS)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .mode       (mode),
    .rx_idle    (rx_idle),
    .rx         (rx),
    .axis       (axis),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rxEn       (rxEn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ce_cnt = 0;
  initial forever begin
    @(negedge clk);
    ce_cnt = (ce_cnt + 1) % CE_DIV;
    clk_en = (ce_cnt == 0);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: expected bytes {tlast,tdata} and expected pulse totals.
  logic [8:0] exp_q[$];
  int exp_perr = 0, exp_ferr = 0, exp_ovr = 0;

  function automatic bit ref_parity(input logic [7:0] d, input logic [3:0] m);
    int ones;
    ones = $countones(d);
    if (m[1]) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  // Monitor: a handshake happened at the edge between two negedges when tvalid was
  // already up and the ready seen now (driven just after the previous negedge) was high.
  logic [8:0] got_q[$];
  int         got_t[$];
  int         n_perr = 0, n_ferr = 0, n_ovr = 0;
  logic       v_prev = 1'b0;
  logic [7:0] d_prev = 8'h00;
  logic       l_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      v_prev = 1'b0;
    end else begin
      if (v_prev) begin
        if (axis.rx_tready) begin
          got_q.push_back({l_prev, d_prev});
          got_t.push_back(cyc);
        end else begin
          chk("axis_hold", 32'({axis.rx_tvalid, axis.rx_tlast, axis.rx_tdata}),
              32'({1'b1, l_prev, d_prev}));
        end
      end
      v_prev = axis.rx_tvalid;
      d_prev = axis.rx_tdata;
      l_prev = axis.rx_tlast;
      if (parity_err) n_perr++;
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
    end
  end

  task automatic set_ready(input logic v);
    @(negedge clk);
    #1 axis.rx_tready = v;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [3:0] m, input bit bad_par, input bit bad_stop);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (m[1] | m[2]) q.push_back(ref_parity(d, m) ^ bad_par);
    if (!m[0]) q.push_back(1'b1);
    q.push_back(!bad_stop);
    foreach (q[i]) begin
      rx = q[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_perr"}, 32'(n_perr), 32'(exp_perr));
    chk({tag, "_ferr"}, 32'(n_ferr), 32'(exp_ferr));
    chk({tag, "_ovr"},  32'(n_ovr),  32'(exp_ovr));
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  logic [3:0] modes [6] = '{4'b0001, 4'b0000, 4'b0011, 4'b0101, 4'b0111, 4'b0100};

  initial begin
    logic [7:0] d;
    logic [3:0] m;
    bit         bp;
    int         t2;

    axis.rx_tready = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_tvalid", 32'(axis.rx_tvalid), 32'd0);
    chk("rst_tdata",  32'(axis.rx_tdata),  32'd0);
    chk("rst_tlast",  32'(axis.rx_tlast),  32'd0);
    chk("rst_perr",   32'(parity_err),     32'd0);
    chk("rst_ferr",   32'(frame_err),      32'd0);
    chk("rst_ovr",    32'(overrun),        32'd0);
    chk("rst_rxen",   32'(rxEn),           32'd0);
    rst = 1'b0;
    idle_bits(2);

    // Basic 8N1 byte.
    mode = 4'b0001;
    send_frame(8'hA5, mode, 1'b0, 1'b0);
    idle_bits(2);
    exp_q.push_back({1'b0, 8'hA5});
    chk("basic_rxen", 32'(rxEn), 32'd0);
    check_rx("basic");

    // Even parity, correct then wrong parity bit.
    mode = 4'b0011;
    send_frame(8'h03, mode, 1'b0, 1'b0);
    send_frame(8'h03, mode, 1'b1, 1'b0);
    idle_bits(2);
    exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b0, 8'h03});
    exp_perr++;
    check_rx("parity");

    // Randomized frames over the frame formats.
    for (int i = 0; i < 8; i++) begin
      m = modes[$urandom_range(0, 5)];
      d = 8'($urandom);
      bp = (m[1] | m[2]) && ($urandom_range(0, 2) == 0);
      mode = m;
      send_frame(d, m, bp, 1'b0);
      exp_q.push_back({1'b0, d});
      if (bp) exp_perr++;
      idle_bits($urandom_range(0, 1));
    end
    idle_bits(1);
    check_rx("random");

    // Bad second stop bit, line held low as a break, then a good frame.
    mode = 4'b0000;
    send_frame(8'h96, mode, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    idle_bits(2);
    send_frame(8'h5A, mode, 1'b0, 1'b0);
    idle_bits(2);
    exp_ferr++;
    exp_q.push_back({1'b0, 8'h5A});
    check_rx("ferr");

    // Short low glitch is a false start.
    mode = 4'b0001;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    chk("glitch_rxen_hi", 32'(rxEn), 32'd1);
    idle_bits(1);
    chk("glitch_rxen_lo", 32'(rxEn), 32'd0);
    chk("glitch_tvalid", 32'(axis.rx_tvalid), 32'd0);
    check_rx("glitch");

    // Overrun while the output is stalled.
    set_ready(1'b0);
    send_frame(8'h11, mode, 1'b0, 1'b0);
    send_frame(8'h22, mode, 1'b0, 1'b0);
    idle_bits(1);
    chk("ovr_tvalid", 32'(axis.rx_tvalid), 32'd1);
    chk("ovr_tdata",  32'(axis.rx_tdata),  32'h11);
    exp_ovr++;
    set_ready(1'b1);
    idle_bits(1);
    exp_q.push_back({1'b0, 8'h11});
    check_rx("ovr");

    // Idle-gap tlast with a 3 bit-time gap.
    mode = 4'b1001;
    rx_idle = 16'd3;
    send_frame(8'h01, mode, 1'b0, 1'b0);
    t2 = cyc;
    send_frame(8'h02, mode, 1'b0, 1'b0);
    idle_bits(5);
    chk("tlast_n", 32'(got_t.size()), 32'd2);
    if (got_t.size() >= 2) begin
      chk("tlast_t0", 32'(got_t[0] >= t2 && got_t[0] <= t2 + BIT_CLKS), 32'd1);
      chk("tlast_t1", 32'(got_t[1] >= t2 + 796 && got_t[1] <= t2 + 814), 32'd1);
    end
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h02});
    check_rx("tlast");

    // rx_idle = 0: every byte carries tlast.
    rx_idle = 16'd0;
    d = 8'($urandom);
    send_frame(d, mode, 1'b0, 1'b0);
    idle_bits(1);
    exp_q.push_back({1'b1, d});
    check_rx("tlast0");

    // Reset in the middle of the data bits.
    mode = 4'b0001;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("mid_rxen", 32'(rxEn), 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_tvalid", 32'(axis.rx_tvalid), 32'd0);
    chk("mid_rst_tdata",  32'(axis.rx_tdata),  32'd0);
    chk("mid_rst_tlast",  32'(axis.rx_tlast),  32'd0);
    chk("mid_rst_rxen",   32'(rxEn),           32'd0);
    rst = 1'b0;
    idle_bits(2);
    send_frame(8'h3C, mode, 1'b0, 1'b0);
    idle_bits(2);
    exp_q.push_back({1'b0, 8'h3C});
    check_rx("after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gj_axis_uart_rx.md
Name: gj_axis_uart_rx

Overview:
- UART receiver for the gjAxisUart pair. It oversamples the serial `rx` line, validates the start, parity and stop bits, and delivers bytes on an AXI-Stream master interface.
- Frame format, parity and stop-bit options mirror the TX `mode` encoding, so one register drives both directions.
- Optional idle-gap detection marks the last byte of a burst with `rx_tlast`.

Parameters:
- OVS, 16, clk_en ticks per bit time. Even, ≥ 8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- clk_en  input  1  oversample tick; all timing advances only when this is 1
- mode  input  4  [0] 0: 2 stop bits, 1: 1 stop bit; [1] even parity; [2] odd parity ([1] wins if both are set); [3] enable idle-gap tlast
- rx_idle  input  16  idle gap, in bit times, that marks end of burst
- rx  input  1  asynchronous serial input
- rx_tvalid  output  1  AXIS valid
- rx_tready  input  1  AXIS ready
- rx_tdata  output  8  received byte
- rx_tlast  output  1  last byte before idle gap
- parity_err  output  1  1-clk pulse
- frame_err  output  1  1-clk pulse
- overrun  output  1  1-clk pulse, byte dropped
- rxEn  output  1  frame reception in progress

Behaviour:
- Input synchronizer: 2-FF on `rx`, reset to 1. All logic uses the synchronized value `rxs`.
- Reset values: rx_tvalid=0, rx_tdata=0, rx_tlast=0, all error pulses 0, rxEn=0, state IDLE, pending buffer empty. Reset mid-frame aborts the frame with no output.
- Sub-tick counter `tcnt` runs 0..OVS-1. Bit counter `bcnt` runs 0..7. Both change only on clk_en.
- FSM:
  - IDLE: on rxs=0 go to START, tcnt=0, rxEn=1.
  - START: at tcnt=OVS/2-1 sample. If 1 (false start) go to IDLE, rxEn=0. If 0, go to DATA; from then on each bit is sampled every OVS ticks at its centre.
  - DATA: 8 bits, LSB first, shifted into a shift register. After bit 7, go to PARITY if mode[1]|mode[2], else STOP1.
  - PARITY: expected bit is ^data for even parity, ~^data for odd. A mismatch sets a sticky parity flag for this frame.
  - STOP1: sample. If 0, pulse frame_err, discard the byte, go to BREAK. If 1, go to STOP2 when mode[0]=0, else to DONE.
  - STOP2: same check as STOP1.
  - BREAK: wait for rxs=1, then IDLE.
  - DONE (one clk): if the parity flag is set, pulse parity_err; the byte is still delivered. Load the byte into the pending buffer. Go to IDLE, rxEn=0.
- Pending buffer release, mode[3]=0: release immediately with tlast=0.
- Pending buffer release, mode[3]=1:
  - Idle counter starts at DONE and counts bit times (OVS ticks each) while in IDLE.
  - Counter reaching rx_idle releases the buffer with tlast=1. rx_idle=0 gives tlast=1 on every byte, released at DONE.
  - A validated start bit (START to DATA) first releases the buffer with tlast=0. A false start does not release it.
- Output register and release:
  - Output register empty, or being accepted in the same cycle (tvalid&tready): load it, rx_tvalid=1.
  - Output register full and not accepted: pulse overrun and drop the pending byte; the old byte is kept.
- AXIS rules: tdata/tlast are stable while tvalid=1 and tready=0. tvalid falls the cycle after acceptance unless reloaded. tready does not depend on clk_en.
- Simultaneous frame_err and parity mismatch: only frame_err pulses.

Optional Feature:
- GJAXISUARTRX_MAJVOTE_EN
  - Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of samples at tcnt OVS/2-2, OVS/2-1 and OVS/2. Sampling points are unchanged.
  - Undefined: single sample at tcnt=OVS/2-1.

Decomposition:
- Shared package gj_axis_uart_pkg, used by TX and RX:
  - mode bit index constants: STOP1B=0, PAR_EVEN=1, PAR_ODD=2, NOP_EN=3
  - FSM state enum
  - frame-length constant
- One sub-module, gj_uart_rx_sampler: synchronizer, tcnt, and the optional majority vote. It produces `bit_strobe` and `bit_val`.

Test Plan:
- OVS=16, mode=4'b0001, send 0xA5 -> rx_tdata=0xA5, rx_tvalid=1, tlast=0, no errors, rxEn low after stop.
- mode=4'b0011, send 0x03 with parity 0 -> 0x03, no error. Then 0x03 with parity 1 -> 0x03 delivered plus one parity_err pulse.
- mode=4'b0000, second stop bit=0 -> frame_err pulse, no tvalid. Line held low 20 bits, then high, then 0x5A -> only 0x5A output.
- 4-tick low glitch on idle line -> no tvalid, rxEn returns to 0.
- rx_tready=0, send 0x11 then 0x22 -> tvalid with 0x11, one overrun pulse. Raising tready yields only 0x11.
- mode=4'b1001, rx_idle=3, send 0x01 and 0x02 back-to-back, then idle -> 0x01 tlast=0 at start of 0x02. 0x02 tlast=1 exactly 3 bit times after its stop sample.
- Reset asserted mid-DATA -> all outputs 0, next full frame received correctly.
